// File: rtl/sirv_gnrl_sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sirv_gnrl_sync_fifo_if
//   Valid/ready handshake bundle for sirv_gnrl_sync_fifo.
//   Write half: i_vld (producer has a beat), i_rdy (FIFO can accept), i_dat.
//   Read half : o_vld (beat available), o_rdy (consumer takes beat), o_dat.
//   Modports:
//     slave  - the FIFO side (drives i_rdy, o_vld, o_dat)
//     master - the producer/consumer environment (drives i_vld, i_dat, o_rdy)
// -----------------------------------------------------------------------------
interface sirv_gnrl_sync_fifo_if #(
  parameter int DW = 32
);
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat
  );

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat
  );
endinterface

// File: rtl/sirv_gnrl_sync_fifo.sv
// -----------------------------------------------------------------------------
// sirv_gnrl_sync_fifo
//   General synchronous valid/ready FIFO. Beats pushed on the write half are
//   delivered in order on the read half. Storage is a load-enabled register
//   array without reset; pointers and count are reset.
//
//   Parameters:
//     DP - depth in entries (power of two, >= 2)
//     DW - data width in bits
//   Ports:
//     clk   - clock, rising edge
//     rst   - asynchronous active-high reset
//     bus   - handshake bundle (slave modport): i_vld/i_rdy/i_dat, o_vld/o_rdy/o_dat
//     count - number of stored entries, 0..DP
//     full  - count == DP
//     empty - count == 0
//
//   Optional feature macro: SIRV_GNRL_FIFO_BYPASS_EN
//     When defined, an empty FIFO falls through: a beat offered on the write
//     half is presented on the read half in the same cycle, and if taken there
//     it is never written into storage.
// -----------------------------------------------------------------------------
module sirv_gnrl_sync_fifo #(
  parameter  int DP = 8,
  parameter  int DW = 32,
  localparam int AW = $clog2(DP)
) (
  input  logic                        clk,
  input  logic                        rst,
  sirv_gnrl_sync_fifo_if.slave        bus,
  output logic [AW:0]                 count,
  output logic                        full,
  output logic                        empty
);

  generate
    if ((DP < 2) || ((DP & (DP - 1)) != 0)) begin : g_bad_dp
      $error("sirv_gnrl_sync_fifo: DP must be a power of two >= 2");
    end
  endgenerate

  // Pointers carry one extra MSB as a wrap flag so full/empty can be told apart
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] mem_q [DP];

  logic push;
  logic pop;
  logic byp;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = cnt_q;

  // Acceptance depends only on the registered full flag, so a pop in the same
  // cycle never frees a slot for a push while full.
  assign bus.i_rdy = ~full;

`ifdef SIRV_GNRL_FIFO_BYPASS_EN
  // Fall-through: a beat consumed straight from the write half never touches
  // storage, so both push and pop are suppressed for that cycle.
  assign byp       = empty & bus.i_vld & bus.o_rdy;
  assign bus.o_vld = ~empty | bus.i_vld;
  assign bus.o_dat = empty ? bus.i_dat : mem_q[rptr_q[AW-1:0]];
`else
  assign byp       = 1'b0;
  assign bus.o_vld = ~empty;
  assign bus.o_dat = mem_q[rptr_q[AW-1:0]];
`endif

  assign push = bus.i_vld & bus.i_rdy & ~byp;
  assign pop  = bus.o_vld & bus.o_rdy & ~byp;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Data array is deliberately left out of reset; only written on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= bus.i_dat;
    end
  end

endmodule
